fb_wb_arbiter: RTL and testbench

- Writeback-stage arbiter. Collects results from three producers (ALU, load/store unit, multiply/divide unit) and serialises them onto the single register-file write port (we/waddr/wdata).
- Sits between the execute/memory stages and the register file.
- Owns x0 write suppression.
- Keeps the write port quiescent when idle, because the register file forwards wdata whenever a read address equals waddr, whether or not we is set.

---
 rtl/fb_wb_arbiter_pkg.sv | 16 +
 rtl/fb_wb_rr2.sv | 26 ++
 rtl/fb_wb_arbiter.sv | 108 ++++++++++
 tb/tb_fb_wb_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fb_wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: the round-robin source encoding
// and default widths.
package fb_wb_arbiter_pkg;

  localparam int FB_32BITS = 32;
  localparam int FB_RAW    = 5;

  localparam logic FB_WB_SRC_LSU = 1'b0;
  localparam logic FB_WB_SRC_MDU = 1'b1;

  typedef enum logic {
    SRC_LSU = FB_WB_SRC_LSU,
    SRC_MDU = FB_WB_SRC_MDU
  } wb_src_e;

endpackage

// File: rtl/fb_wb_rr2.sv
// Two-requester round-robin arbiter. ptr names the requester that wins a tie; after a
// grant with advance set, ptr moves to the requester that was not granted.
module fb_wb_rr2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr
);

  assign gnt[0] = req[0] & ((ptr == 1'b0) | !req[1]);
  assign gnt[1] = req[1] & ((ptr == 1'b1) | !req[0]);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance && gnt[0]) begin
      ptr <= 1'b1;
    end else if (advance && gnt[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/fb_wb_arbiter.sv
// Writeback arbiter: merges ALU, LSU and MDU results onto one register-file write port.
// Optional statistics counters are enabled by defining FB_WB_STATS_EN.
module fb_wb_arbiter
  import fb_wb_arbiter_pkg::*;
#(
  parameter int XLEN = FB_32BITS,
  parameter int RAW  = FB_RAW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [RAW-1:0]  alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [RAW-1:0]  lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [RAW-1:0]  mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata
`ifdef FB_WB_STATS_EN
  ,
  output logic [31:0]     stat_commits,
  output logic [31:0]     stat_lsu_stall,
  output logic [31:0]     stat_mdu_stall
`endif
);

  logic [1:0]      rr_req;
  logic [1:0]      rr_gnt;
  logic            rr_ptr;
  logic            sel_valid;
  logic [RAW-1:0]  sel_rd;
  logic [XLEN-1:0] sel_data;

  // ALU has absolute priority; LSU/MDU only compete when the ALU slot is free.
  assign rr_req = {mdu_valid, lsu_valid} & {2{!reset && !alu_valid}};

  // The writeback port never stalls, so every grant advances the pointer.
  fb_wb_rr2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (rr_req),
    .advance (1'b1),
    .gnt     (rr_gnt),
    .ptr     (rr_ptr)
  );

  assign lsu_ready = rr_gnt[FB_WB_SRC_LSU];
  assign mdu_ready = rr_gnt[FB_WB_SRC_MDU];

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (lsu_ready) begin
      sel_valid = 1'b1;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
    end else if (mdu_ready) begin
      sel_valid = 1'b1;
      sel_rd    = mdu_rd;
      sel_data  = mdu_data;
    end
  end

  // The register file forwards wdata on address match even without we, so idle and
  // x0 slots drive the whole port to zero rather than holding stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (sel_valid && (sel_rd != '0)) begin
      rf_we    <= 1'b1;
      rf_waddr <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end
  end

`ifdef FB_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_commits   <= '0;
      stat_lsu_stall <= '0;
      stat_mdu_stall <= '0;
    end else begin
      if (rf_we)                   stat_commits   <= stat_commits + 32'd1;
      if (lsu_valid && !lsu_ready) stat_lsu_stall <= stat_lsu_stall + 32'd1;
      if (mdu_valid && !mdu_ready) stat_mdu_stall <= stat_mdu_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_wb_arbiter.sv
// Directed table-driven bench for fb_wb_arbiter, plus hand-written reset and
// statistics sequences (the latter only when FB_WB_STATS_EN is defined).
module tb_fb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid, mdu_valid;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic        lsu_ready, mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef FB_WB_STATS_EN
  logic [31:0] stat_commits, stat_lsu_stall, stat_mdu_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fb_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_rd    (mdu_rd),
    .mdu_data  (mdu_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
`ifdef FB_WB_STATS_EN
    ,
    .stat_commits   (stat_commits),
    .stat_lsu_stall (stat_lsu_stall),
    .stat_mdu_stall (stat_mdu_stall)
`endif
  );

  typedef struct {
    bit          av;
    logic [4:0]  ar;
    logic [31:0] ad;
    bit          lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    bit          mv;
    logic [4:0]  mr;
    logic [31:0] md;
    bit          e_lrdy;
    bit          e_mrdy;
    bit          e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit av, logic [4:0] ar, logic [31:0] ad,
                              bit lv, logic [4:0] lr, logic [31:0] ld,
                              bit mv, logic [4:0] mr, logic [31:0] md,
                              bit e_lrdy, bit e_mrdy,
                              bit e_we, logic [4:0] e_waddr, logic [31:0] e_wdata);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad;
    v.lv = lv; v.lr = lr; v.ld = ld;
    v.mv = mv; v.mr = mr; v.md = md;
    v.e_lrdy = e_lrdy; v.e_mrdy = e_mrdy;
    v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drive at negedge, check readies mid-cycle, check registered outputs #1 after posedge.
  task automatic apply(input vec_t v, input bit rst, input string tag);
    @(negedge clk);
    reset     = rst;
    alu_valid = v.av; alu_rd = v.ar; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lr; lsu_data = v.ld;
    mdu_valid = v.mv; mdu_rd = v.mr; mdu_data = v.md;
    #1;
    check({tag, " lsu_ready"}, {31'd0, lsu_ready}, {31'd0, v.e_lrdy});
    check({tag, " mdu_ready"}, {31'd0, mdu_ready}, {31'd0, v.e_mrdy});
    check({tag, " ready_onehot"}, {31'd0, lsu_ready & mdu_ready}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, " rf_we"},    {31'd0, rf_we},    {31'd0, v.e_we});
    check({tag, " rf_waddr"}, {27'd0, rf_waddr}, {27'd0, v.e_waddr});
    check({tag, " rf_wdata"}, rf_wdata,          v.e_wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle;
    idle = mk(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0);

    //          alu            lsu                mdu                rdy    out
    vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0,0,               0,0, 1,5,32'hDEADBEEF));
    vecs.push_back(idle);
    vecs.push_back(mk(1,1,32'h11, 1,2,32'h22, 1,3,32'h33,          0,0, 1,1,32'h11));
    vecs.push_back(mk(0,0,0,      1,2,32'h22, 1,3,32'h33,          1,0, 1,2,32'h22));
    vecs.push_back(mk(0,0,0,      0,0,0,      1,3,32'h33,          0,1, 1,3,32'h33));
    vecs.push_back(mk(0,0,0,      1,4,32'hA1, 1,6,32'hB1,          1,0, 1,4,32'hA1));
    vecs.push_back(mk(0,0,0,      1,4,32'hA2, 1,6,32'hB1,          0,1, 1,6,32'hB1));
    vecs.push_back(mk(0,0,0,      1,4,32'hA2, 1,6,32'hB2,          1,0, 1,4,32'hA2));
    vecs.push_back(mk(0,0,0,      1,4,32'hA3, 1,6,32'hB2,          0,1, 1,6,32'hB2));
    vecs.push_back(mk(0,0,0,      1,4,32'hA3, 1,6,32'hB3,          1,0, 1,4,32'hA3));
    vecs.push_back(mk(0,0,0,      0,0,0,      1,6,32'hB3,          0,1, 1,6,32'hB3));
    vecs.push_back(mk(0,0,0,      1,0,32'h1234, 0,0,0,             1,0, 0,0,0));
    vecs.push_back(mk(0,0,0,      1,8,32'h88, 1,9,32'h99,          0,1, 1,9,32'h99));
    vecs.push_back(mk(0,0,0,      1,8,32'h88, 0,0,0,               1,0, 1,8,32'h88));
    vecs.push_back(mk(1,10,32'hAA, 0,0,0,     1,12,32'hCC,         0,0, 1,10,32'hAA));
    vecs.push_back(mk(0,0,0,      0,0,0,      1,12,32'hCC,         0,1, 1,12,32'hCC));
    vecs.push_back(mk(1,0,32'hFFFF, 1,13,32'h1, 1,13,32'h2,        0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,      1,13,32'h1, 1,13,32'h2,          1,0, 1,13,32'h1));
    vecs.push_back(mk(0,0,0,      0,0,0,      1,13,32'h2,          0,1, 1,13,32'h2));
    vecs.push_back(idle);

    reset = 1'b1;
    alu_valid = 0; lsu_valid = 0; mdu_valid = 0;
    alu_rd = 0; lsu_rd = 0; mdu_rd = 0;
    alu_data = 0; lsu_data = 0; mdu_data = 0;

    // Reset state: readies gated low even with all producers valid.
    apply(idle, 1'b1, "rst0");
    apply(mk(1,3,32'h5, 1,2,32'h6, 1,4,32'h7, 0,0, 0,0,0), 1'b1, "rst1");

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Reset right after an MDU grant to rd 7: the in-flight write is dropped.
    apply(mk(0,0,0, 1,14,32'hE, 1,7,32'h77, 1,0, 1,14,32'hE), 1'b0, "mid_a");
    apply(mk(0,0,0, 1,15,32'hF, 1,7,32'h77, 0,1, 1,7,32'h77), 1'b0, "mid_b");
    apply(mk(0,0,0, 1,15,32'hF, 1,16,32'h16, 0,0, 0,0,0), 1'b1, "mid_rst");
    apply(idle, 1'b0, "mid_after");

    // Pointer is moved to MDU, then reset must return it to LSU.
    apply(mk(0,0,0, 1,17,32'h17, 0,0,0, 1,0, 1,17,32'h17), 1'b0, "rr_a");
    apply(idle, 1'b1, "rr_rst");
    apply(mk(0,0,0, 1,18,32'h18, 1,19,32'h19, 1,0, 1,18,32'h18), 1'b0, "rr_b");
    apply(idle, 1'b0, "rr_idle");

`ifdef FB_WB_STATS_EN
    apply(idle, 1'b1, "st_rst");
    for (int i = 0; i < 3; i++)
      apply(mk(1,5'(i+1),32'(i), 1,0,32'h5A, 0,0,0, 0,0, 1,5'(i+1),32'(i)), 1'b0, "st_stall");
    apply(mk(0,0,0, 1,0,32'h5A, 0,0,0, 1,0, 0,0,0), 1'b0, "st_x0");
    for (int i = 3; i < 10; i++)
      apply(mk(1,5'(i+1),32'(i), 0,0,0, 0,0,0, 0,0, 1,5'(i+1),32'(i)), 1'b0, "st_alu");
    apply(idle, 1'b0, "st_idle0");
    apply(idle, 1'b0, "st_idle1");
    check("stat_commits", stat_commits, 32'd10);
    check("stat_lsu_stall", stat_lsu_stall, 32'd3);
    check("stat_mdu_stall", stat_mdu_stall, 32'd0);

    @(negedge clk);
    force dut.stat_commits = 32'hFFFF_FFFF;
    #1;
    release dut.stat_commits;
    apply(mk(1,20,32'h20, 0,0,0, 0,0,0, 0,0, 1,20,32'h20), 1'b0, "st_wrap_w");
    apply(idle, 1'b0, "st_wrap_i");
    check("stat_commits_wrap", stat_commits, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
